// File: rtl/traffic_phase_ctrl.sv
// Four-phase intersection controller: one green at a time, bounded green length,
// all-red clearance between greens and round-robin arbitration over latched requests.
module traffic_phase_ctrl #(
    parameter int unsigned GREEN_MIN    = 4,
    parameter int unsigned GREEN_MAX    = 16,
    parameter int unsigned CLEAR_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pedestrian_req,
    input  logic       up_req,
    input  logic       down_req,
    input  logic       turn_req,
    output logic       pedestrian_green,
    output logic       up_green,
    output logic       down_green,
    output logic       turn_green,
    output logic       all_red,
    output logic [3:0] pending
);

    localparam int unsigned CntMax = (GREEN_MAX > CLEAR_CYCLES) ? GREEN_MAX : CLEAR_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax) + 1;

    localparam logic [CntW-1:0] GreenMinLast = CntW'(GREEN_MIN - 1);
    localparam logic [CntW-1:0] GreenMaxLast = CntW'(GREEN_MAX - 1);
    localparam logic [CntW-1:0] ClearLast    = CntW'(CLEAR_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StGreen,
        StClear
    } state_e;

    state_e          state;
    logic [CntW-1:0] cnt;
    logic [1:0]      ptr;
    logic [3:0]      green;

    logic [3:0] req;
    logic [3:0] eff;
    logic [1:0] sel;
    logic [1:0] idx;
    logic [3:0] sel_oh;

    assign req = {turn_req, down_req, up_req, pedestrian_req};
    // The green register is itself the mask of the active phase.
    assign eff = (pending | req) & ~green;

    // Circular first-set search starting at ptr; lowest offset is visited last and wins.
    always_comb begin
        sel = ptr;
        idx = ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (eff[idx]) begin
                sel = idx;
            end
        end
        sel_oh = 4'b0001 << sel;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= StIdle;
            cnt     <= '0;
            ptr     <= '0;
            green   <= '0;
            pending <= '0;
        end else begin
            pending <= eff;
            unique case (state)
                StIdle: begin
                    if (|eff) begin
                        state   <= StGreen;
                        green   <= sel_oh;
                        cnt     <= '0;
                        ptr     <= sel + 2'd1;
                        pending <= eff & ~sel_oh;
                    end
                end
                StGreen: begin
                    if (cnt == GreenMaxLast || (cnt >= GreenMinLast && |eff)) begin
                        state <= StClear;
                        green <= '0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                StClear: begin
                    if (cnt == ClearLast) begin
                        cnt <= '0;
                        if (|eff) begin
                            state   <= StGreen;
                            green   <= sel_oh;
                            ptr     <= sel + 2'd1;
                            pending <= eff & ~sel_oh;
                        end else begin
                            state <= StIdle;
                        end
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                default: begin
                    state <= StIdle;
                    green <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign pedestrian_green = green[0];
    assign up_green         = green[1];
    assign down_green       = green[2];
    assign turn_green       = green[3];
    assign all_red          = ~|green;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed and randomized checks of traffic_phase_ctrl with GREEN_MIN=4, GREEN_MAX=16,
// CLEAR_CYCLES=2; cycle 0 is the first cycle after reset is released.
module tb_traffic_phase_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       pedestrian_req, up_req, down_req, turn_req;
    logic       pedestrian_green, up_green, down_green, turn_green;
    logic       all_red;
    logic [3:0] pending;
    logic [3:0] g;

    int vectors     = 0;
    int miscompares = 0;

    traffic_phase_ctrl #(
        .GREEN_MIN   (4),
        .GREEN_MAX   (16),
        .CLEAR_CYCLES(2)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .pedestrian_req  (pedestrian_req),
        .up_req          (up_req),
        .down_req        (down_req),
        .turn_req        (turn_req),
        .pedestrian_green(pedestrian_green),
        .up_green        (up_green),
        .down_green      (down_green),
        .turn_green      (turn_green),
        .all_red         (all_red),
        .pending         (pending)
    );

    assign g = {turn_green, down_green, up_green, pedestrian_green};

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input logic [3:0] r);
        {turn_req, down_req, up_req, pedestrian_req} = r;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_req(4'b0000);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic chk(input string tag, input int c, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, c, got, exp);
        end
    endtask

    // Greens, all_red and (optionally) pending for one cycle.
    task automatic chk_out(input string tag, input int c, input logic [3:0] eg,
                           input bit chk_p, input logic [3:0] ep);
        chk({tag, ".green"}, c, 32'(g), 32'(eg));
        chk({tag, ".all_red"}, c, 32'(all_red), 32'(eg == 4'b0000));
        if (chk_p) chk({tag, ".pending"}, c, 32'(pending), 32'(ep));
    endtask

    initial begin
        logic [3:0] eg, ep, r, prev;
        int         len, gap;
        bit         had_run;
        bit [3:0]   waiting;
        int         wait_c[4];

        do_reset();
        chk_out("reset", 0, 4'b0000, 1'b1, 4'b0000);

        // Single up request.
        for (int c = 0; c <= 20; c++) begin
            set_req(c == 0 ? 4'b0010 : 4'b0000);
            eg = (c >= 1 && c <= 16) ? 4'b0010 : 4'b0000;
            chk_out("single", c, eg, 1'b1, 4'b0000);
            tick();
        end

        // Up and turn together: up served first at GREEN_MIN, then turn to GREEN_MAX.
        do_reset();
        for (int c = 0; c <= 26; c++) begin
            set_req(c == 0 ? 4'b1010 : 4'b0000);
            eg = (c >= 1 && c <= 4) ? 4'b0010 : (c >= 7 && c <= 22) ? 4'b1000 : 4'b0000;
            ep = (c >= 1 && c <= 6) ? 4'b1000 : 4'b0000;
            chk_out("two", c, eg, 1'b1, ep);
            tick();
        end

        // All four together: round-robin order ped, up, down, turn.
        do_reset();
        for (int c = 0; c <= 38; c++) begin
            set_req(c == 0 ? 4'b1111 : 4'b0000);
            if (c >= 1 && c <= 4)        eg = 4'b0001;
            else if (c >= 7 && c <= 10)  eg = 4'b0010;
            else if (c >= 13 && c <= 16) eg = 4'b0100;
            else if (c >= 19 && c <= 34) eg = 4'b1000;
            else                         eg = 4'b0000;
            if (c >= 1 && c <= 6)        ep = 4'b1110;
            else if (c >= 7 && c <= 12)  ep = 4'b1100;
            else if (c >= 13 && c <= 18) ep = 4'b1000;
            else                         ep = 4'b0000;
            chk_out("four", c, eg, 1'b1, ep);
            tick();
        end

        // Fairness: ped held high, up pulsed in cycle 2; up must be served before ped again.
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            set_req(c == 2 ? 4'b0011 : 4'b0001);
            if (c >= 1 && c <= 4)       eg = 4'b0001;
            else if (c >= 7 && c <= 10) eg = 4'b0010;
            else if (c >= 13)           eg = 4'b0001;
            else                        eg = 4'b0000;
            chk_out("fair", c, eg, 1'b0, 4'b0000);
            tick();
        end

        // Mid-green reset with down pending; only a fresh request restarts service.
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            set_req(c == 0 ? 4'b0110 : c == 9 ? 4'b1000 : 4'b0000);
            reset = (c == 3);
            if (c >= 1 && c <= 3) chk_out("midrst", c, 4'b0010, 1'b1, 4'b0100);
            else if (c >= 10)     chk_out("midrst", c, 4'b1000, 1'b1, 4'b0000);
            else                  chk_out("midrst", c, 4'b0000, 1'b1, 4'b0000);
            tick();
        end
        reset = 1'b0;

        // Random stress with invariant, run-length, clearance and service-latency checks.
        do_reset();
        prev    = 4'b0000;
        len     = 0;
        gap     = 0;
        had_run = 1'b0;
        waiting = '0;
        for (int i = 0; i < 4; i++) wait_c[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            chk("onehot0", c, 32'($onehot0(g)), 32'd1);
            chk("all_red_inv", c, 32'(all_red), 32'(g == 4'b0000));
            if (prev != 4'b0000 && g != prev) begin
                chk("run_len_ok", c, 32'(len >= 4 && len <= 16), 32'd1);
                gap = 0;
            end
            if (g == 4'b0000) gap++;
            if (g != 4'b0000 && g != prev) begin
                if (had_run) chk("clear_gap_ok", c, 32'(gap >= 2), 32'd1);
                had_run = 1'b1;
                len     = 1;
            end else if (g != 4'b0000) begin
                len++;
            end
            prev = g;
            for (int i = 0; i < 4; i++) begin
                r[i] = ($urandom_range(0, 11) == 0);
                if (g[i] && waiting[i]) begin
                    chk("service_ok", c, 32'(wait_c[i] <= 56), 32'd1);
                    waiting[i] = 1'b0;
                end else if (waiting[i] && wait_c[i] > 56) begin
                    chk("service_ok", c, 32'd0, 32'd1);
                    waiting[i] = 1'b0;
                end
                if (!g[i] && r[i] && !waiting[i]) begin
                    waiting[i] = 1'b1;
                    wait_c[i]  = 0;
                end
            end
            set_req(r);
            tick();
            for (int i = 0; i < 4; i++) if (waiting[i]) wait_c[i]++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
